mc_controller: RTL and testbench

//  Multicycle ARM controller. Sequences the shared-ALU, shared-memory datapath through FETCH/DECODE/EXECUTE/WB states.

---
 rtl/mc_pkg.sv | 78 +++++++
 rtl/cond_unit.sv | 68 ++++++
 rtl/mc_controller.sv | 197 +++++++++++++++++++
 tb/tb_mc_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StBranch
    } state_t;

    // ALUControl
    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    // ResultSrc
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // ImmSrc
    localparam logic [1:0] ImmDp  = 2'b00;
    localparam logic [1:0] ImmMem = 2'b01;
    localparam logic [1:0] ImmBr  = 2'b10;

    // RegSrc
    localparam logic [1:0] RegSrcNone = 2'b00;
    localparam logic [1:0] RegSrcB    = 2'b01;
    localparam logic [1:0] RegSrcStr  = 2'b10;

    // Op field
    localparam logic [1:0] OpDp  = 2'b00;
    localparam logic [1:0] OpMem = 2'b01;
    localparam logic [1:0] OpBr  = 2'b10;

    // Data-processing commands, Funct[4:1]
    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdRsc = 4'b0111;
    localparam logic [3:0] CmdOrr = 4'b1100;

    // Condition codes
    localparam logic [3:0] CondEq = 4'h0;
    localparam logic [3:0] CondNe = 4'h1;
    localparam logic [3:0] CondCs = 4'h2;
    localparam logic [3:0] CondCc = 4'h3;
    localparam logic [3:0] CondMi = 4'h4;
    localparam logic [3:0] CondPl = 4'h5;
    localparam logic [3:0] CondVs = 4'h6;
    localparam logic [3:0] CondVc = 4'h7;
    localparam logic [3:0] CondHi = 4'h8;
    localparam logic [3:0] CondLs = 4'h9;
    localparam logic [3:0] CondGe = 4'ha;
    localparam logic [3:0] CondLt = 4'hb;
    localparam logic [3:0] CondGt = 4'hc;
    localparam logic [3:0] CondLe = 4'hd;
    localparam logic [3:0] CondAl = 4'he;

    // True for the data-processing commands this datapath implements.
    function automatic logic dp_cmd_valid(input logic [3:0] cmd);
        return (cmd == CmdAnd) || (cmd == CmdSub) || (cmd == CmdAdd) ||
               (cmd == CmdRsc) || (cmd == CmdOrr);
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register, condition evaluation and gated flag writes.
module cond_unit
    import mc_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       latch_cond,
    input  logic       write_nz,
    input  logic       write_cv,
    output logic       cond_ex,
    output logic       carry
);

    logic [3:0] flags_q;
    logic       cond_ex_q;
    logic       cond_now;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Evaluate the condition field against the current (pre-instruction) flags.
    always_comb begin
        cond_now = 1'b1;
        case (cond)
            CondEq:  cond_now = z;
            CondNe:  cond_now = ~z;
            CondCs:  cond_now = c;
            CondCc:  cond_now = ~c;
            CondMi:  cond_now = n;
            CondPl:  cond_now = ~n;
            CondVs:  cond_now = v;
            CondVc:  cond_now = ~v;
            CondHi:  cond_now = c & ~z;
            CondLs:  cond_now = ~c | z;
            CondGe:  cond_now = (n == v);
            CondLt:  cond_now = (n != v);
            CondGt:  cond_now = ~z & (n == v);
            CondLe:  cond_now = z | (n != v);
            default: cond_now = 1'b1;  // AL, and 1111 treated as AL
        endcase
    end

    // Flags and latched condition; writes only land for instructions that passed.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= RESET_FLAGS;
            cond_ex_q <= 1'b0;
        end else begin
            if (latch_cond) begin
                cond_ex_q <= cond_now;
            end
            if (write_nz && cond_ex_q) begin
                flags_q[3:2] <= alu_flags[3:2];
            end
            if (write_cv && cond_ex_q) begin
                flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    assign cond_ex = cond_ex_q;
    assign carry   = flags_q[1];

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM controller: FSM sequencing, ALU decode and datapath controls.
module mc_controller
    import mc_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegWrite,
    output logic       RSCSignal,
    output logic       CarryFlag,
    output logic       Undef
);

    state_t     state_q, state_d;
    logic [3:0] cmd;
    logic       rd_pc;
    logic       cond_ex;
    logic       latch_cond;
    logic       write_nz;
    logic       write_cv;

    assign cmd   = Funct[4:1];
    assign rd_pc = (Rd == 4'hf);

    cond_unit #(
        .RESET_FLAGS(RESET_FLAGS)
    ) u_cond_unit (
        .clk       (clk),
        .reset     (reset),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .latch_cond(latch_cond),
        .write_nz  (write_nz),
        .write_cv  (write_cv),
        .cond_ex   (cond_ex),
        .carry     (CarryFlag)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Immediate and register-source selects depend only on the instruction class.
    always_comb begin
        ImmSrc = ImmDp;
        RegSrc = RegSrcNone;
        case (Op)
            OpMem: begin
                ImmSrc = ImmMem;
                RegSrc = Funct[0] ? RegSrcNone : RegSrcStr;
            end
            OpBr: begin
                ImmSrc = ImmBr;
                RegSrc = RegSrcB;
            end
            default: ;
        endcase
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = ResAluOut;
        ALUControl = AluAdd;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SrcBReg;
        RegWrite   = 1'b0;
        RSCSignal  = 1'b0;
        Undef      = 1'b0;
        latch_cond = 1'b0;
        write_nz   = 1'b0;
        write_cv   = 1'b0;

        unique case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                PCWrite   = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SrcBFour;
                ResultSrc  = ResAluResult;
                latch_cond = 1'b1;
                case (Op)
                    OpDp: begin
                        if (dp_cmd_valid(cmd)) begin
                            state_d = Funct[5] ? StExecuteI : StExecuteR;
                        end else begin
                            Undef   = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    OpMem:   state_d = StMemAdr;
                    OpBr:    state_d = StBranch;
                    default: begin
                        Undef   = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StExecuteR, StExecuteI: begin
                ALUSrcA = 1'b0;
                ALUSrcB = (state_q == StExecuteI) ? SrcBImm : SrcBReg;
                unique case (cmd)
                    CmdAdd: ALUControl = AluAdd;
                    CmdSub: ALUControl = AluSub;
                    CmdAnd: ALUControl = AluAnd;
                    CmdOrr: ALUControl = AluOrr;
                    CmdRsc: begin
                        ALUControl = AluSub;
                        RSCSignal  = 1'b1;
                    end
                    default: ALUControl = AluAdd;
                endcase
                // Logical ops leave C and V alone.
                write_nz = Funct[0];
                write_cv = Funct[0] & ((cmd == CmdAdd) || (cmd == CmdSub) || (cmd == CmdRsc));
                state_d  = StAluWb;
            end
            StAluWb: begin
                ResultSrc = ResAluOut;
                RegWrite  = cond_ex & ~rd_pc;
                PCWrite   = cond_ex & rd_pc;
                state_d   = StFetch;
            end
            StMemAdr: begin
                ALUSrcA = 1'b0;
                ALUSrcB = SrcBImm;
                state_d = Funct[0] ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                ResultSrc = ResAluOut;
                AdrSrc    = 1'b1;
                state_d   = StMemWb;
            end
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = cond_ex & ~rd_pc;
                PCWrite   = cond_ex & rd_pc;
                state_d   = StFetch;
            end
            StMemWrite: begin
                ResultSrc = ResAluOut;
                AdrSrc    = 1'b1;
                MemWrite  = cond_ex;
                state_d   = StFetch;
            end
            StBranch: begin
                ALUSrcA   = 1'b0;
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAluResult;
                PCWrite   = cond_ex;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset kills every write strobe in the same cycle.
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            Undef    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed vectors, reset abort, random instructions.
module tb_mc_controller;

    localparam logic [3:0] RstFlags = 4'b0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, RSCSignal, CarryFlag, Undef;
    logic [1:0] ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;

    always #5 clk = ~clk;

    mc_controller #(
        .RESET_FLAGS(RstFlags)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUControl(ALUControl),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .RegWrite  (RegWrite),
        .RSCSignal (RSCSignal),
        .CarryFlag (CarryFlag),
        .Undef     (Undef)
    );

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [1:0] regs;
        logic       rw;
        logic       rsc;
        logic       carry;
        logic       undef;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [3:0]  aluf;
        int          len;
        logic        rw;
        logic        pcw;
        logic        mw;
        logic        undef;
        logic        rsc;
    } vec_t;

    typedef struct {
        int   len;
        logic rw;
        logic pcw;
        logic mw;
        logic undef;
        logic rsc;
    } obs_t;

    int         checks = 0;
    int         passes = 0;
    logic [3:0] m_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic out_t sample();
        out_t o;
        o = '{pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite, rs: ResultSrc,
              alu: ALUControl, srca: ALUSrcA, srcb: ALUSrcB, imm: ImmSrc, regs: RegSrc,
              rw: RegWrite, rsc: RSCSignal, carry: CarryFlag, undef: Undef};
        return o;
    endfunction

    // ARM condition codes come in complementary pairs; odd codes invert (except AL/1111).
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic r;
        case (c[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] & ~f[2];
            3'd5: r = (f[3] == f[0]);
            3'd6: r = ~f[2] & (f[3] == f[0]);
            default: r = 1'b1;
        endcase
        if (c[3:1] != 3'd7 && c[0]) r = ~r;
        return r;
    endfunction

    function automatic logic is_undef(input logic [1:0] op, input logic [5:0] funct);
        return (op == 2'b11) ||
               (op == 2'b00 && !(funct[4:1] inside {4'b0000, 4'b0010, 4'b0100, 4'b0111, 4'b1100}));
    endfunction

    function automatic int model_len(input logic [1:0] op, input logic [5:0] funct);
        if (is_undef(op, funct)) return 2;
        if (op == 2'b10) return 3;
        if (op == 2'b01) return funct[0] ? 5 : 4;
        return 4;
    endfunction

    // Expected outputs for cycle k (0 = FETCH) of one instruction.
    function automatic out_t model_cycle(input int k, input logic [1:0] op, input logic [5:0] funct,
                                         input logic [3:0] rd, input logic pass, input logic carry);
        out_t o;
        logic [3:0] cmd;
        cmd = funct[4:1];
        o = '0;
        o.carry = carry;
        o.imm   = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        o.regs  = (op == 2'b10) ? 2'b01 : (op == 2'b01 && !funct[0]) ? 2'b10 : 2'b00;
        if (k == 0) begin
            o.irw = 1; o.srca = 1; o.srcb = 2'b10; o.rs = 2'b10; o.pcw = 1;
        end else if (k == 1) begin
            o.srca = 1; o.srcb = 2'b10; o.rs = 2'b10; o.undef = is_undef(op, funct);
        end else if (op == 2'b00) begin
            if (k == 2) begin
                o.srcb = funct[5] ? 2'b01 : 2'b00;
                case (cmd)
                    4'b0010: o.alu = 2'b01;
                    4'b0111: begin o.alu = 2'b01; o.rsc = 1; end
                    4'b0000: o.alu = 2'b10;
                    4'b1100: o.alu = 2'b11;
                    default: o.alu = 2'b00;
                endcase
            end else begin
                o.rw = pass && rd != 15; o.pcw = pass && rd == 15;
            end
        end else if (op == 2'b01) begin
            if (k == 2) o.srcb = 2'b01;
            else if (k == 3) begin
                o.adr = 1; o.mw = pass && !funct[0];
            end else begin
                o.rs = 2'b01; o.rw = pass && rd != 15; o.pcw = pass && rd == 15;
            end
        end else begin
            o.srcb = 2'b01; o.rs = 2'b10; o.pcw = pass;
        end
        return o;
    endfunction

    // Runs one instruction starting in FETCH; ends sampled in the following FETCH.
    task automatic run_instr(input logic [31:0] w, input logic [3:0] af, output obs_t ob);
        logic       pass;
        int         mlen;
        bit         done;
        out_t       got;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        op = w[27:26]; funct = w[25:20]; rd = w[15:12];
        Cond = w[31:28]; Op = op; Funct = funct; Rd = rd; ALUFlags = af;
        pass = cond_pass(w[31:28], m_flags);
        mlen = model_len(op, funct);
        ob = '{len: 0, rw: 0, pcw: 0, mw: 0, undef: 0, rsc: 0};
        done = 0;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
                if (IRWrite) begin
                    ob.len = k;
                    done = 1;
                    break;
                end
            end
            got = sample();
            check($sformatf("cycle%0d of %h", k, w), 32'(got),
                  32'(model_cycle(k, op, funct, rd, pass, m_flags[1])));
            ob.rw    |= RegWrite;
            ob.mw    |= MemWrite;
            ob.undef |= Undef;
            ob.rsc   |= RSCSignal;
            if (k > 0) ob.pcw |= PCWrite;
            if (k == 2 && op == 2'b00 && !is_undef(op, funct) && pass && funct[0]) begin
                m_flags[3:2] = af[3:2];
                if (funct[4:1] inside {4'b0100, 4'b0010, 4'b0111}) m_flags[1:0] = af[1:0];
            end
        end
        if (!done) check($sformatf("timeout %h", w), 32'd0, 32'd1);
        check($sformatf("latency %h", w), 32'(ob.len), 32'(mlen));
    endtask

    initial begin
        vec_t  vecs[$];
        obs_t  ob;
        out_t  exp_o;

        vecs.push_back('{"add",     32'hE0821003, 4'h0, 4, 1, 0, 0, 0, 0});
        vecs.push_back('{"ldr",     32'hE5910004, 4'h0, 5, 1, 0, 0, 0, 0});
        vecs.push_back('{"subs",    32'hE0532001, 4'h4, 4, 1, 0, 0, 0, 0});
        vecs.push_back('{"beq_tk",  32'h0A000002, 4'h0, 3, 0, 1, 0, 0, 0});
        vecs.push_back('{"strne",   32'h15801000, 4'h0, 4, 0, 0, 0, 0, 0});
        vecs.push_back('{"rsc",     32'hE0E10002, 4'h0, 4, 1, 0, 0, 0, 1});
        vecs.push_back('{"op11",    32'hEC000000, 4'h0, 2, 0, 0, 0, 1, 0});
        vecs.push_back('{"adds",    32'hE0921003, 4'h0, 4, 1, 0, 0, 0, 0});
        vecs.push_back('{"beq_nt",  32'h0A000002, 4'h0, 3, 0, 0, 0, 0, 0});
        vecs.push_back('{"eor",     32'hE0210002, 4'h0, 2, 0, 0, 0, 1, 0});
        vecs.push_back('{"add_pc",  32'hE082F003, 4'h0, 4, 0, 1, 0, 0, 0});
        vecs.push_back('{"str",     32'hE5801000, 4'h0, 4, 0, 0, 1, 0, 0});
        vecs.push_back('{"ldr_pc",  32'hE591F004, 4'h0, 5, 0, 1, 0, 0, 0});
        vecs.push_back('{"orr_imm", 32'hE3811001, 4'h0, 4, 1, 0, 0, 0, 0});

        reset = 1; Cond = 0; Op = 0; Funct = 0; Rd = 0; ALUFlags = 0;
        m_flags = RstFlags;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        exp_o = model_cycle(0, 2'b00, 6'd0, 4'd0, 1'b0, RstFlags[1]);
        exp_o.pcw = 0;
        exp_o.irw = 0;
        check("reset_state", 32'(sample()), 32'(exp_o));
        reset = 0;

        foreach (vecs[i]) begin
            run_instr(vecs[i].word, vecs[i].aluf, ob);
            check({vecs[i].name, "_len"},   32'(ob.len),   32'(vecs[i].len));
            check({vecs[i].name, "_rw"},    32'(ob.rw),    32'(vecs[i].rw));
            check({vecs[i].name, "_pcw"},   32'(ob.pcw),   32'(vecs[i].pcw));
            check({vecs[i].name, "_mw"},    32'(ob.mw),    32'(vecs[i].mw));
            check({vecs[i].name, "_undef"}, 32'(ob.undef), 32'(vecs[i].undef));
            check({vecs[i].name, "_rsc"},   32'(ob.rsc),   32'(vecs[i].rsc));
        end

        // Set C, then abort a STR in MEMWRITE with reset.
        run_instr(32'hE0532001, 4'h2, ob);
        check("carry_set", 32'(CarryFlag), 32'd1);
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'h1; ALUFlags = 4'h0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
        end
        check("memwrite_before_reset", 32'(MemWrite), 32'd1);
        reset = 1;
        #1;
        check("memwrite_under_reset", 32'(MemWrite), 32'd0);
        check("pcwrite_under_reset", 32'(PCWrite), 32'd0);
        @(negedge clk);
        reset = 0;
        m_flags = RstFlags;
        #1;
        check("after_reset_fetch", 32'(sample()),
              32'(model_cycle(0, 2'b01, 6'b011000, 4'h1, 1'b1, RstFlags[1])));
        run_instr(32'h2A000002, 4'h0, ob);
        check("bcs_after_reset_pcw", 32'(ob.pcw), 32'(RstFlags[1]));

        for (int i = 0; i < 250; i++) begin
            logic [3:0]  c, rd, af;
            logic [1:0]  op;
            logic [5:0]  funct;
            logic [3:0]  legal [5];
            legal = '{4'b0000, 4'b0010, 4'b0100, 4'b0111, 4'b1100};
            c     = 4'($urandom);
            op    = 2'($urandom_range(0, 3));
            funct = 6'($urandom);
            if (op == 2'b00 && $urandom_range(0, 4) != 0) funct[4:1] = legal[$urandom_range(0, 4)];
            rd    = ($urandom_range(0, 7) == 0) ? 4'hf : 4'($urandom_range(0, 14));
            af    = 4'($urandom);
            run_instr({c, op, funct, 4'h0, rd, 12'h000}, af, ob);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
